// File: rtl/register_file_multichannel.sv
// Multichannel vector register file: two registered read ports, per-channel write
// masking with write-first forwarding, frame-relative addressing and a clear sweep.

module register_file_multichannel_lane #(
    parameter int CHANNEL_WIDTH = 32,
    parameter int ADDR_WIDTH    = 7
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     we_i,
    input  logic [ADDR_WIDTH-1:0]    waddr_i,
    input  logic [CHANNEL_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0]    raddr0_i,
    input  logic [ADDR_WIDTH-1:0]    raddr1_i,
    output logic [CHANNEL_WIDTH-1:0] rdata0_o,
    output logic [CHANNEL_WIDTH-1:0] rdata1_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [CHANNEL_WIDTH-1:0] mem_q [DEPTH];
    logic [CHANNEL_WIDTH-1:0] rd0_q, rd1_q;

    always_ff @(posedge Clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Write-first: a same-edge write to the read row wins over the stored word.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            rd0_q <= (we_i && waddr_i == raddr0_i) ? wdata_i : mem_q[raddr0_i];
            rd1_q <= (we_i && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
        end
    end

    assign rdata0_o = rd0_q;
    assign rdata1_o = rd1_q;
endmodule

module register_file_multichannel #(
    parameter int CHANNELS          = 3,
    parameter int CHANNEL_WIDTH     = 32,
    parameter int ADDR_WIDTH        = 7,
    parameter int SPR_CONTROL0_ADDR = 2,
    parameter int SPR_CONTROL1_ADDR = 3,
    parameter bit CLEAR_ON_RESET    = 1'b1
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic [ADDR_WIDTH-1:0]             iReadAddress0,
    input  logic                              iReadRelative0,
    input  logic [ADDR_WIDTH-1:0]             iReadAddress1,
    input  logic                              iReadRelative1,
    input  logic [CHANNELS-1:0]               iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]             iWriteAddress,
    input  logic                              iWriteRelative,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0] iData,
    input  logic                              iClearRequest,
    output logic                              oBusy,
    output logic                              oWriteDropped,
    output logic [ADDR_WIDTH-1:0]             oFrameOffset,
    output logic [ADDR_WIDTH-1:0]             oIndexRegister,
    output logic [CHANNEL_WIDTH-1:0]          oThreadControlRegister,
    output logic [CHANNELS*CHANNEL_WIDTH-1:0] oData0,
    output logic [CHANNELS*CHANNEL_WIDTH-1:0] oData1
);
    localparam int DW = CHANNELS * CHANNEL_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] SPR0     = ADDR_WIDTH'(SPR_CONTROL0_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPR1     = ADDR_WIDTH'(SPR_CONTROL1_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    start_q;
    logic [ADDR_WIDTH-1:0]   frame_q, index_q;
    logic [CHANNEL_WIDTH-1:0] tctl_q;
    logic                    drop_q;

    logic                    busy;
    logic [ADDR_WIDTH-1:0]   wea, ea0, ea1, mem_waddr;
    logic                    spr0_hit, spr1_hit;

    assign busy = (state_q == CLEAR);
    assign wea  = iWriteRelative ? iWriteAddress + frame_q : iWriteAddress;
    assign ea0  = iReadRelative0 ? iReadAddress0 + frame_q : iReadAddress0;
    assign ea1  = iReadRelative1 ? iReadAddress1 + frame_q : iReadAddress1;
    assign mem_waddr = busy ? cnt_q : wea;

    assign spr0_hit = !busy && (wea == SPR0);
    assign spr1_hit = !busy && (wea == SPR1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= 1'b0;
        end
    end

    // start_q is only high for the first edge after reset release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (iClearRequest || start_q) state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ROW) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            frame_q <= '0;
            index_q <= '0;
            tctl_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (spr1_hit && iWriteEnable[0])
                frame_q <= iData[DW-CHANNEL_WIDTH +: ADDR_WIDTH];
            if (spr1_hit && iWriteEnable[CHANNELS-1])
                index_q <= iData[ADDR_WIDTH-1:0];
            if (spr0_hit && iWriteEnable[CHANNELS-1])
                tctl_q <= iData[CHANNEL_WIDTH-1:0];
            drop_q <= busy && (|iWriteEnable);
        end
    end

    // Index is visible combinationally during the write that loads it.
    assign oIndexRegister = (Reset && spr1_hit && iWriteEnable[CHANNELS-1])
                            ? iData[ADDR_WIDTH-1:0] : index_q;
    assign oBusy                  = busy;
    assign oWriteDropped          = drop_q;
    assign oFrameOffset           = frame_q;
    assign oThreadControlRegister = tctl_q;

    // Channel 0 occupies the most significant slice of the row.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam int LO = (CHANNELS - 1 - k) * CHANNEL_WIDTH;
        register_file_multichannel_lane #(
            .CHANNEL_WIDTH(CHANNEL_WIDTH),
            .ADDR_WIDTH   (ADDR_WIDTH)
        ) u_lane (
            .Clock   (Clock),
            .Reset   (Reset),
            .we_i    (busy | iWriteEnable[k]),
            .waddr_i (mem_waddr),
            .wdata_i (busy ? '0 : iData[LO +: CHANNEL_WIDTH]),
            .raddr0_i(ea0),
            .raddr1_i(ea1),
            .rdata0_o(oData0[LO +: CHANNEL_WIDTH]),
            .rdata1_o(oData1[LO +: CHANNEL_WIDTH])
        );
    end
endmodule

// File: tb/tb_register_file_multichannel.sv
// Scoreboard bench for register_file_multichannel: expected read data is pushed
// when a read is issued and popped one edge later.

module tb_register_file_multichannel;
    localparam int CH = 3, CW = 32, AW = 7, DEPTH = 128, DW = CH * CW;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] iReadAddress0, iReadAddress1, iWriteAddress;
    logic          iReadRelative0, iReadRelative1, iWriteRelative, iClearRequest;
    logic [CH-1:0] iWriteEnable;
    logic [DW-1:0] iData;
    logic          oBusy, oWriteDropped;
    logic [AW-1:0] oFrameOffset, oIndexRegister;
    logic [CW-1:0] oThreadControlRegister;
    logic [DW-1:0] oData0, oData1;

    register_file_multichannel dut (
        .Clock(Clock), .Reset(Reset),
        .iReadAddress0(iReadAddress0), .iReadRelative0(iReadRelative0),
        .iReadAddress1(iReadAddress1), .iReadRelative1(iReadRelative1),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress),
        .iWriteRelative(iWriteRelative), .iData(iData),
        .iClearRequest(iClearRequest), .oBusy(oBusy), .oWriteDropped(oWriteDropped),
        .oFrameOffset(oFrameOffset), .oIndexRegister(oIndexRegister),
        .oThreadControlRegister(oThreadControlRegister),
        .oData0(oData0), .oData1(oData1)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] mdl [DEPTH];
    logic [AW-1:0] fo_m = '0, idx_m = '0;
    logic [CW-1:0] tc_m = '0;
    bit            busy_m = 1'b0;
    int            cnt_m = 0;
    logic [DW-1:0] sb0 [$];
    logic [DW-1:0] sb1 [$];
    int            n_chk = 0, n_pass = 0;

    // Drive one cycle of inputs and advance the reference model by that cycle.
    task automatic set_inputs(input logic [CH-1:0] we, input int wa, input bit wrel,
                              input logic [DW-1:0] d, input int ra0, input bit rel0,
                              input int ra1, input bit rel1, input bit clr, input bit chk);
        logic [AW-1:0] wea, ea0, ea1;
        logic [DW-1:0] e0, e1;
        iWriteEnable = we; iWriteAddress = AW'(wa); iWriteRelative = wrel; iData = d;
        iReadAddress0 = AW'(ra0); iReadRelative0 = rel0;
        iReadAddress1 = AW'(ra1); iReadRelative1 = rel1;
        iClearRequest = clr;
        wea = wrel ? AW'(wa + int'(fo_m)) : AW'(wa);
        ea0 = rel0 ? AW'(ra0 + int'(fo_m)) : AW'(ra0);
        ea1 = rel1 ? AW'(ra1 + int'(fo_m)) : AW'(ra1);
        e0 = mdl[ea0];
        e1 = mdl[ea1];
        if (busy_m) begin
            if (ea0 == AW'(cnt_m)) e0 = '0;
            if (ea1 == AW'(cnt_m)) e1 = '0;
            mdl[cnt_m] = '0;
            if (cnt_m == DEPTH - 1) busy_m = 1'b0;
            cnt_m++;
        end else begin
            for (int k = 0; k < CH; k++) begin
                int lo;
                lo = (CH - 1 - k) * CW;
                if (we[k]) begin
                    if (wea == ea0) e0[lo +: CW] = d[lo +: CW];
                    if (wea == ea1) e1[lo +: CW] = d[lo +: CW];
                    mdl[wea][lo +: CW] = d[lo +: CW];
                end
            end
            if (wea == AW'(3) && we[0])      fo_m  = d[DW-CW +: AW];
            if (wea == AW'(3) && we[CH-1])   idx_m = d[AW-1:0];
            if (wea == AW'(2) && we[CH-1])   tc_m  = d[CW-1:0];
            if (clr) begin busy_m = 1'b1; cnt_m = 0; end
        end
        if (chk) begin sb0.push_back(e0); sb1.push_back(e1); end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic idle();
        set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        int n;
        logic [DW-1:0] e;
        set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        #1;
        n_chk++;
        if ({oBusy, oWriteDropped, oFrameOffset, oIndexRegister, oThreadControlRegister} !== '0)
            $display("FAIL reset_status: got %h want 0",
                     {oBusy, oWriteDropped, oFrameOffset, oIndexRegister, oThreadControlRegister});
        else n_pass++;
        n_chk++;
        if ({oData0, oData1} !== '0) $display("FAIL reset_data: got %h %h want 0", oData0, oData1);
        else n_pass++;
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        busy_m = 1'b1; cnt_m = 0;
        n = 0;
        while (oBusy === 1'b1 && n < 300) begin idle(); n++; end
        n_chk++;
        if (n !== 128) $display("FAIL reset_sweep_len: got %0d want 128", n); else n_pass++;
        set_inputs('0, 0, 0, '0, 0, 0, 5, 0, 0, 1); tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL clr_row0: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front(); n_chk++;
        if (oData1 !== e) $display("FAIL clr_row5: got %h want %h", oData1, e); else n_pass++;
        set_inputs('0, 0, 0, '0, 127, 0, 127, 0, 0, 1); tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL clr_row127: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front();
    endtask

    task automatic test_forward();
        logic [DW-1:0] e;
        set_inputs(3'b111, 10, 0, {32'h11111111, 32'h22222222, 32'h33333333}, 10, 0, 10, 0, 0, 1);
        tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL fwd_all_p0: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front(); n_chk++;
        if (oData1 !== e) $display("FAIL fwd_all_p1: got %h want %h", oData1, e); else n_pass++;
        set_inputs(3'b010, 10, 0, {32'h0, 32'h0000AAAA, 32'h0}, 10, 0, 10, 0, 0, 1);
        tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL fwd_mask_p0: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front(); n_chk++;
        if (oData1 !== e) $display("FAIL fwd_mask_p1: got %h want %h", oData1, e); else n_pass++;
        set_inputs('0, 0, 0, '0, 10, 0, 9, 0, 0, 1);
        tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL mask_stored: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front(); n_chk++;
        if (oData1 !== e) $display("FAIL row9_read: got %h want %h", oData1, e); else n_pass++;
    endtask

    task automatic test_spr();
        logic [DW-1:0] e;
        set_inputs(3'b011, 2, 0, {32'hA2A2A2A2, 32'hB2B2B2B2, 32'hC2C2C2C2}, 0, 0, 0, 0, 0, 0);
        tick();
        set_inputs(3'b111, 3, 0, {32'h7E, 32'h0, 32'h05}, 4, 1, 4, 0, 0, 1);
        #1;
        n_chk++;
        if (oIndexRegister !== 7'h05) $display("FAIL idx_bypass: got %h want 05", oIndexRegister); else n_pass++;
        n_chk++;
        if (oFrameOffset !== 7'h00) $display("FAIL fo_early: got %h want 00", oFrameOffset); else n_pass++;
        tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL fo_same_cycle_rel: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front();
        n_chk++;
        if (oFrameOffset !== 7'h7E) $display("FAIL fo_load: got %h want 7e", oFrameOffset); else n_pass++;
        n_chk++;
        if (oIndexRegister !== idx_m) $display("FAIL idx_flop: got %h want %h", oIndexRegister, idx_m); else n_pass++;
        set_inputs('0, 0, 0, '0, 4, 1, 2, 0, 0, 1);
        tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL rel_read_wrap: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front(); n_chk++;
        if (oData1 !== e) $display("FAIL abs_row2: got %h want %h", oData1, e); else n_pass++;
        set_inputs(3'b111, 3, 1, {32'h01010101, 32'h02020202, 32'h03030303}, 0, 0, 0, 0, 0, 0);
        tick();
        set_inputs('0, 0, 0, '0, 1, 0, 3, 0, 0, 1);
        tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL rel_write_row1: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front(); n_chk++;
        if (oData1 !== e) $display("FAIL row3_untouched: got %h want %h", oData1, e); else n_pass++;
        n_chk++;
        if (oFrameOffset !== fo_m) $display("FAIL fo_hold: got %h want %h", oFrameOffset, fo_m); else n_pass++;
    endtask

    task automatic test_thread_ctrl();
        n_chk++;
        if (oThreadControlRegister !== 32'h0) $display("FAIL tc_init: got %h want 0", oThreadControlRegister); else n_pass++;
        set_inputs(3'b100, 2, 0, {32'h0, 32'h0, 32'hDEADBEEF}, 0, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (oThreadControlRegister !== 32'hDEADBEEF) $display("FAIL tc_load: got %h want deadbeef", oThreadControlRegister); else n_pass++;
        set_inputs(3'b001, 2, 0, {32'h55555555, 32'h0, 32'h12345678}, 0, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (oThreadControlRegister !== tc_m) $display("FAIL tc_masked: got %h want %h", oThreadControlRegister, tc_m); else n_pass++;
    endtask

    task automatic test_clear();
        int n;
        logic [DW-1:0] e;
        set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 1, 0);
        tick();
        n = 0;
        while (oBusy === 1'b1 && n < 300) begin
            if (n == 3)       set_inputs(3'b111, 20, 0, {3{32'hFFFF0000}}, 0, 0, 0, 0, 0, 0);
            else if (n == 4)  set_inputs(3'b111, 2, 0, {32'h0, 32'h0, 32'hCAFEF00D}, 0, 0, 0, 0, 0, 0);
            else if (n == 5)  set_inputs('0, 0, 0, '0, 10, 0, 9, 0, 0, 1);
            else if (n == 10) set_inputs('0, 0, 0, '0, 10, 0, 11, 0, 0, 1);
            else if (n == 60) set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 1, 0);
            else              set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
            tick();
            if (n == 3 || n == 4) begin
                n_chk++;
                if (oWriteDropped !== 1'b1) $display("FAIL drop_flag_c%0d: got %b want 1", n, oWriteDropped); else n_pass++;
            end
            if (n == 4) begin
                n_chk++;
                if (oThreadControlRegister !== 32'hDEADBEEF) $display("FAIL tc_busy_write: got %h want deadbeef", oThreadControlRegister); else n_pass++;
            end
            if (n == 5 || n == 10) begin
                n_chk++;
                if (oWriteDropped !== 1'b0) $display("FAIL drop_clear_c%0d: got %b want 0", n, oWriteDropped); else n_pass++;
                e = sb0.pop_front(); n_chk++;
                if (oData0 !== e) $display("FAIL sweep_read_p0_c%0d: got %h want %h", n, oData0, e); else n_pass++;
                e = sb1.pop_front(); n_chk++;
                if (oData1 !== e) $display("FAIL sweep_read_p1_c%0d: got %h want %h", n, oData1, e); else n_pass++;
            end
            n++;
        end
        n_chk++;
        if (n !== 128) $display("FAIL clear_len: got %0d want 128", n); else n_pass++;
        set_inputs('0, 0, 0, '0, 20, 0, 2, 0, 0, 1);
        tick();
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL row20_after: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front(); n_chk++;
        if (oData1 !== e) $display("FAIL row2_after: got %h want %h", oData1, e); else n_pass++;
    endtask

    task automatic test_reset_midsweep();
        int n;
        logic [DW-1:0] e;
        set_inputs(3'b111, 100, 0, {32'h64646464, 32'h0, 32'hFACEFACE}, 0, 0, 0, 0, 0, 0);
        tick();
        set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int c = 0; c < 50; c++) begin
            if (c == 49) set_inputs('0, 0, 0, '0, 100, 0, 100, 0, 0, 1);
            else         set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        e = sb0.pop_front(); n_chk++;
        if (oData0 !== e) $display("FAIL pre_reset_read: got %h want %h", oData0, e); else n_pass++;
        e = sb1.pop_front();
        Reset = 1'b0;
        busy_m = 1'b0; cnt_m = 0; fo_m = '0; idx_m = '0; tc_m = '0;
        #1;
        n_chk++;
        if ({oBusy, oWriteDropped, oFrameOffset, oIndexRegister, oThreadControlRegister} !== '0)
            $display("FAIL midreset_status: got %h want 0",
                     {oBusy, oWriteDropped, oFrameOffset, oIndexRegister, oThreadControlRegister});
        else n_pass++;
        n_chk++;
        if ({oData0, oData1} !== '0) $display("FAIL midreset_data: got %h %h want 0", oData0, oData1); else n_pass++;
        tick(); tick();
        Reset = 1'b1;
        tick();
        busy_m = 1'b1; cnt_m = 0;
        n_chk++;
        if (oBusy !== 1'b1) $display("FAIL resweep_start: got %b want 1", oBusy); else n_pass++;
        n = 0;
        while (oBusy === 1'b1 && n < 300) begin
            if (n == 60) set_inputs('0, 0, 0, '0, 100, 0, 60, 0, 0, 1);
            else         set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
            tick();
            if (n == 60) begin
                e = sb0.pop_front(); n_chk++;
                if (oData0 !== e) $display("FAIL resweep_from0: got %h want %h", oData0, e); else n_pass++;
                e = sb1.pop_front(); n_chk++;
                if (oData1 !== e) $display("FAIL resweep_fwd: got %h want %h", oData1, e); else n_pass++;
            end
            n++;
        end
        n_chk++;
        if (n !== 128) $display("FAIL resweep_len: got %0d want 128", n); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        set_inputs('0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_forward();
        test_spr();
        test_thread_ctrl();
        test_clear();
        test_reset_midsweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
